// File: rtl/axi_interconnect_width_convert_rdata_pkg.sv
// Shared types for the read-data width converter: RESP codes, split command, packer states.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axi_interconnect_width_convert_rdata_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // One entry per narrow sub-burst issued by the request splitter (23 bits).
    typedef struct packed {
        logic [7:0] len;      // narrow beats - 1
        logic [7:0] offset;   // start address[7:0]
        logic [2:0] size;     // log2(narrow beats per wide beat)
        logic [2:0] reqsize;  // narrow AxSIZE
        logic       tlast;    // last sub-burst of the original burst
    } split_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_SEND = 2'd2
    } pack_state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_interconnect_sync_fifo.sv
// Generic synchronous FIFO with registered head, used as the split-command queue.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module axi_interconnect_sync_fifo
    import axi_interconnect_width_convert_rdata_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = (AW > 0) ? AW : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full queue still lands.
    assign do_wr = push && (!full || do_rd);
    assign head  = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_interconnect_width_convert_rdata.sv
// Packs narrow R beats into wide R beats by address lane, merging RRESP and regenerating RLAST.
// Latency: wide beat valid the cycle after the completing narrow handshake; PACK and SEND never overlap.
// Backpressure: m_rready drops while a wide beat waits for s_rready; split_en into a full queue sets cmd_ovf.
module axi_interconnect_width_convert_rdata
    import axi_interconnect_width_convert_rdata_pkg::*;
#(
    parameter  int WIDTH_ID    = 4,
    parameter  int WIDTH_SDATA = 128,
    parameter  int WIDTH_MDATA = 32,
    parameter  int WIDTH_RUSER = 1,
    parameter  int CMD_DEPTH   = 4,
    parameter  int U_DLY       = 1,
    localparam int W_ID        = (WIDTH_ID > 0) ? WIDTH_ID : 1,
    localparam int W_RUSER     = (WIDTH_RUSER > 0) ? WIDTH_RUSER : 1
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   split_en,
    input  logic [7:0]             split_len,
    input  logic [7:0]             split_offset,
    input  logic [2:0]             split_size,
    input  logic [2:0]             split_reqsize,
    input  logic                   split_tlast,
    output logic                   cmd_ovf,
    input  logic [W_ID-1:0]        m_rid,
    input  logic [WIDTH_MDATA-1:0] m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rlast,
    input  logic [W_RUSER-1:0]     m_ruser,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic [W_ID-1:0]        s_rid,
    output logic [WIDTH_SDATA-1:0] s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rlast,
    output logic [W_RUSER-1:0]     s_ruser,
    output logic                   s_rvalid,
    input  logic                   s_rready
);

    localparam int MLOG2  = clog2(WIDTH_MDATA / 8);
    localparam int SLOG2  = clog2(WIDTH_SDATA / 8);
    localparam int RATIO  = 1 << (SLOG2 - MLOG2);
    localparam int LANE_W = (SLOG2 > MLOG2) ? (SLOG2 - MLOG2) : 1;

    pack_state_t      state;
    pack_state_t      state_nxt;
    split_cmd_t       in_cmd;
    split_cmd_t       head_cmd;
    split_cmd_t       cur_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             load;
    logic [7:0]       beat_cnt;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_nxt;
    logic [LANE_W-1:0] lane_init;
    int               lane_step;
    logic             last_narrow;
    logic             wide_done;
    logic             done_cmd;
    logic             first_beat;
    logic             m_hs;
    logic             s_hs;
    logic [WIDTH_SDATA-1:0] data_buf;
    logic             unused_ok;

    assign in_cmd = '{len: split_len, offset: split_offset, size: split_size,
                      reqsize: split_reqsize, tlast: split_tlast};

    axi_interconnect_sync_fifo #(
        .WIDTH ($bits(split_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk_sys),
        .rst_n     (rst_n),
        .push      (split_en),
        .push_data (in_cmd),
        .pop       (fifo_pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_rready = (state == ST_PACK);
    assign s_rvalid = (state == ST_SEND);
    assign s_rdata  = data_buf;
    assign m_hs     = m_rvalid && m_rready;
    assign s_hs     = s_rvalid && s_rready;

    // Lane arithmetic: reqsize below the narrow bus width still steps one lane.
    assign lane_step   = (int'(cur_cmd.reqsize) > MLOG2) ? (1 << (int'(cur_cmd.reqsize) - MLOG2)) : 1;
    assign lane_nxt    = LANE_W'((int'(lane) + lane_step) % RATIO);
    assign lane_init   = LANE_W'((int'(head_cmd.offset) >> MLOG2) % RATIO);
    assign last_narrow = (beat_cnt == 8'd0);
    // A wide beat closes on a 2^size lane boundary or at the end of the command.
    assign wide_done   = last_narrow || (((int'(lane) + 1) & ((1 << cur_cmd.size) - 1)) == 0);

    // m_rlast is deliberately ignored: the command length decides where bursts end.
    assign unused_ok = ^{m_rlast, cur_cmd.len, cur_cmd.offset} ^ (U_DLY != 0);

    // Packer state register.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, command load and command pop.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = ST_PACK;
                end
            end
            ST_PACK: begin
                if (m_rvalid) begin
                    fifo_pop = last_narrow;
                    if (wide_done) begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (s_rready) begin
                    if (!done_cmd) begin
                        state_nxt = ST_PACK;
                    end else if (!fifo_empty) begin
                        load      = 1'b1;
                        state_nxt = ST_PACK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: command tracking, lane packing, response merge and overflow flag.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cur_cmd    <= '0;
            beat_cnt   <= '0;
            lane       <= '0;
            done_cmd   <= 1'b0;
            first_beat <= 1'b1;
            data_buf   <= '0;
            s_rid      <= '0;
            s_ruser    <= '0;
            s_rresp    <= RESP_OKAY;
            s_rlast    <= 1'b0;
            cmd_ovf    <= 1'b0;
        end else begin
            if (split_en && fifo_full && !fifo_pop) begin
                cmd_ovf <= 1'b1;
            end
            if (load) begin
                cur_cmd  <= head_cmd;
                beat_cnt <= head_cmd.len;
                lane     <= lane_init;
                done_cmd <= 1'b0;
            end
            if (m_hs) begin
                data_buf[lane*WIDTH_MDATA +: WIDTH_MDATA] <= m_rdata;
                beat_cnt <= beat_cnt - 8'd1;
                lane     <= lane_nxt;
                s_rid    <= m_rid;
                s_ruser  <= m_ruser;
                s_rlast  <= last_narrow && cur_cmd.tlast;
                if (last_narrow) begin
                    done_cmd <= 1'b1;
                end
                // First error response within a wide beat wins.
                if (first_beat) begin
                    s_rresp    <= m_rresp;
                    first_beat <= 1'b0;
                end else if (!s_rresp[1] && m_rresp[1]) begin
                    s_rresp <= m_rresp;
                end
            end
            if (s_hs) begin
                first_beat <= 1'b1;
            end
        end
    end

endmodule
